// File: rtl/complex_mag_squared_seq_pkg.sv
// Shared definitions for the absolute-value path: FSM state encodings and default widths.
// The square_root_cal benches import the same constants so both blocks agree on widths.
package complex_mag_squared_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam int DEFAULT_DATA_WIDTH        = 16;
   localparam int DEFAULT_OUTPUT_DATA_WIDTH = 32;

endpackage

// File: rtl/complex_mag_squared_seq_signed_to_magnitude.sv
// Two's-complement to unsigned magnitude; the most negative input maps to 2^(W-1),
// which is representable because the output is unsigned.
module signed_to_magnitude #(
   parameter int DATA_WIDTH = 16
) (
   input  logic signed [DATA_WIDTH-1:0] value,
   output logic        [DATA_WIDTH-1:0] magnitude
);

   always_comb begin
      magnitude = value[DATA_WIDTH-1] ? (~value + 1'b1) : value;
   end

endmodule

// File: rtl/complex_mag_squared_seq.sv
// Bit-serial |Re|^2 + |Im|^2: one shift-add step per enabled clock into a single accumulator,
// with valid/ready handshakes on the sample input and on the result output.
module complex_mag_squared_seq
   import complex_mag_squared_seq_pkg::*;
#(
   parameter int DATA_WIDTH        = DEFAULT_DATA_WIDTH,
   parameter int OUTPUT_DATA_WIDTH = DEFAULT_OUTPUT_DATA_WIDTH
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                enable,
   input  logic signed [DATA_WIDTH-1:0]        dataInRe,
   input  logic signed [DATA_WIDTH-1:0]        dataInIm,
   input  logic                                inputValid,
   output logic                                inputReady,
   output logic        [OUTPUT_DATA_WIDTH-1:0] dataOut,
   output logic                                outputValid,
   input  logic                                outputReady
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   state_t                         state;
   state_t                         state_next;
   logic [DATA_WIDTH-1:0]          mag_re;
   logic [DATA_WIDTH-1:0]          mag_im;
   logic [DATA_WIDTH-1:0]          mag_a;
   logic [DATA_WIDTH-1:0]          mag_b;
   logic [DATA_WIDTH-1:0]          mag_a_next;
   logic [DATA_WIDTH-1:0]          mag_b_next;
   logic [OUTPUT_DATA_WIDTH-1:0]   acc;
   logic [OUTPUT_DATA_WIDTH-1:0]   acc_next;
   logic [OUTPUT_DATA_WIDTH-1:0]   acc_sum;
   logic [OUTPUT_DATA_WIDTH-1:0]   term_a;
   logic [OUTPUT_DATA_WIDTH-1:0]   term_b;
   logic [OUTPUT_DATA_WIDTH-1:0]   result;
   logic [OUTPUT_DATA_WIDTH-1:0]   result_next;
   logic [CNT_W-1:0]               counter;
   logic [CNT_W-1:0]               counter_next;
   logic                           valid;
   logic                           valid_next;

   signed_to_magnitude #(.DATA_WIDTH(DATA_WIDTH)) u_mag_re (
      .value     (dataInRe),
      .magnitude (mag_re)
   );

   signed_to_magnitude #(.DATA_WIDTH(DATA_WIDTH)) u_mag_im (
      .value     (dataInIm),
      .magnitude (mag_im)
   );

   // Each magnitude bit set at position i contributes mag << i, so DATA_WIDTH steps yield mag*mag.
   always_comb begin
      term_a  = mag_a[counter] ? (OUTPUT_DATA_WIDTH'(mag_a) << counter) : '0;
      term_b  = mag_b[counter] ? (OUTPUT_DATA_WIDTH'(mag_b) << counter) : '0;
      acc_sum = acc + term_a + term_b;
   end

   always_comb begin
      state_next   = state;
      mag_a_next   = mag_a;
      mag_b_next   = mag_b;
      acc_next     = acc;
      counter_next = counter;
      result_next  = result;
      valid_next   = valid;
      if (enable) begin
         case (state)
            IDLE: begin
               if (inputValid) begin
                  mag_a_next   = mag_re;
                  mag_b_next   = mag_im;
                  acc_next     = '0;
                  counter_next = '0;
                  state_next   = CALC;
               end
            end
            CALC: begin
               acc_next     = acc_sum;
               counter_next = counter + 1'b1;
               if (counter == LAST_BIT) begin
                  result_next = acc_sum;
                  valid_next  = 1'b1;
                  state_next  = DONE;
               end
            end
            DONE: begin
               if (outputReady) begin
                  valid_next = 1'b0;
                  state_next = IDLE;
               end
            end
            default: begin
               // An illegal encoding discards everything and restarts from a clean IDLE.
               state_next   = IDLE;
               mag_a_next   = '0;
               mag_b_next   = '0;
               acc_next     = '0;
               counter_next = '0;
               result_next  = '0;
               valid_next   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mag_a   <= '0;
         mag_b   <= '0;
         acc     <= '0;
         counter <= '0;
         result  <= '0;
         valid   <= 1'b0;
      end else begin
         mag_a   <= mag_a_next;
         mag_b   <= mag_b_next;
         acc     <= acc_next;
         counter <= counter_next;
         result  <= result_next;
         valid   <= valid_next;
      end
   end

   assign inputReady  = enable && (state == IDLE);
   assign dataOut     = result;
   assign outputValid = valid;

endmodule

// File: tb/tb_complex_mag_squared_seq.sv
// Self-checking bench for complex_mag_squared_seq: directed corners, random samples,
// backpressure, enable stalls and asynchronous reset, checked against plain integer arithmetic.
module tb_complex_mag_squared_seq;

   localparam int DW = 16;
   localparam int OW = 32;
   localparam int WAIT_LIMIT = 200;

   logic                 clock;
   logic                 reset;
   logic                 enable;
   logic signed [DW-1:0] dataInRe;
   logic signed [DW-1:0] dataInIm;
   logic                 inputValid;
   logic                 inputReady;
   logic [OW-1:0]        dataOut;
   logic                 outputValid;
   logic                 outputReady;

   int n_compared = 0;
   int n_failed   = 0;

   complex_mag_squared_seq #(.DATA_WIDTH(DW), .OUTPUT_DATA_WIDTH(OW)) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .dataInRe    (dataInRe),
      .dataInIm    (dataInIm),
      .inputValid  (inputValid),
      .inputReady  (inputReady),
      .dataOut     (dataOut),
      .outputValid (outputValid),
      .outputReady (outputReady)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog time limit expired");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [OW-1:0] model_mag_sq(input int re, input int im);
      longint s;
      s = longint'(re) * longint'(re) + longint'(im) * longint'(im);
      return s[OW-1:0];
   endfunction

   function automatic longint isqrt(input longint v);
      longint r = 0;
      while ((r + 1) * (r + 1) <= v) r++;
      return r;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Presents one sample, waits for acceptance, then counts enabled edges until outputValid.
   task automatic run_sample(input int re, input int im, output int lat);
      int waited = 0;
      while (!inputReady && waited < WAIT_LIMIT) begin
         step();
         waited++;
      end
      dataInRe   = DW'(re);
      dataInIm   = DW'(im);
      inputValid = 1'b1;
      step();
      inputValid = 1'b0;
      lat = 0;
      while (!outputValid && lat < WAIT_LIMIT) begin
         step();
         lat++;
      end
      if (!outputValid) begin
         $display("[TB] FAIL timeout re=%0d im=%0d waited %0d cycles, outputValid never rose", re, im, lat);
         lat = -1;
      end
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      enable      = 1'b1;
      inputValid  = 1'b0;
      outputReady = 1'b0;
      dataInRe    = '0;
      dataInIm    = '0;
      #12;
      n_compared++;
      if (outputValid !== 1'b0) begin
         n_failed++;
         $display("[TB] FAIL reset_valid got %b want 0", outputValid);
      end
      n_compared++;
      if (dataOut !== '0) begin
         n_failed++;
         $display("[TB] FAIL reset_data got %0d want 0", dataOut);
      end
      n_compared++;
      if (inputReady !== 1'b1) begin
         n_failed++;
         $display("[TB] FAIL reset_ready got %b want 1", inputReady);
      end
      enable = 1'b0;
      #1;
      n_compared++;
      if (inputReady !== 1'b0) begin
         n_failed++;
         $display("[TB] FAIL ready_enable_low got %b want 0", inputReady);
      end
      enable = 1'b1;
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_basic();
      int lat;
      outputReady = 1'b1;
      run_sample(3, 4, lat);
      n_compared++;
      if (lat !== DW) begin
         n_failed++;
         $display("[TB] FAIL basic_latency got %0d want %0d", lat, DW);
      end
      n_compared++;
      if (dataOut !== 32'd25) begin
         n_failed++;
         $display("[TB] FAIL basic_value got %0d want 25", dataOut);
      end
      n_compared++;
      if (inputReady !== 1'b0) begin
         n_failed++;
         $display("[TB] FAIL basic_ready_in_done got %b want 0", inputReady);
      end
      step();
      n_compared++;
      if (outputValid !== 1'b0 || inputReady !== 1'b1) begin
         n_failed++;
         $display("[TB] FAIL basic_handoff valid=%b ready=%b want valid=0 ready=1", outputValid, inputReady);
      end
      n_compared++;
      if (dataOut !== 32'd25) begin
         n_failed++;
         $display("[TB] FAIL basic_data_kept got %0d want 25", dataOut);
      end
   endtask

   task automatic test_corners();
      int res[$] = '{-32768, 32767, 0, -213, 3000, -1, 1, -32768};
      int ims[$] = '{-32768, 0, 0, 0, 4000, -1, 32767, 32767};
      int lat;
      logic [OW-1:0] expected;
      outputReady = 1'b1;
      foreach (res[i]) begin
         expected = model_mag_sq(res[i], ims[i]);
         run_sample(res[i], ims[i], lat);
         n_compared++;
         if (dataOut !== expected || lat !== DW) begin
            n_failed++;
            $display("[TB] FAIL corner re=%0d im=%0d got %0d lat %0d want %0d lat %0d",
                     res[i], ims[i], dataOut, lat, expected, DW);
         end
         step();
      end
   endtask

   task automatic test_chain_sqrt();
      int lat;
      outputReady = 1'b1;
      run_sample(3000, 4000, lat);
      n_compared++;
      if (dataOut !== 32'd25000000 || isqrt(longint'(dataOut)) != 5000) begin
         n_failed++;
         $display("[TB] FAIL chain_sqrt got %0d (root %0d) want 25000000 (root 5000)",
                  dataOut, isqrt(longint'(dataOut)));
      end
      step();
   endtask

   task automatic test_random();
      int re;
      int im;
      int lat;
      logic [OW-1:0] expected;
      outputReady = 1'b1;
      for (int n = 0; n < 24; n++) begin
         re = int'($urandom_range(65535)) - 32768;
         im = int'($urandom_range(65535)) - 32768;
         expected = model_mag_sq(re, im);
         run_sample(re, im, lat);
         n_compared++;
         if (dataOut !== expected || lat !== DW) begin
            n_failed++;
            $display("[TB] FAIL random re=%0d im=%0d got %0d lat %0d want %0d lat %0d",
                     re, im, dataOut, lat, expected, DW);
         end
         step();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      int bad = 0;
      logic [OW-1:0] first_exp;
      logic [OW-1:0] second_exp;
      first_exp  = model_mag_sq(-1234, 567);
      second_exp = model_mag_sq(89, -10);
      outputReady = 1'b0;
      run_sample(-1234, 567, lat);
      dataInRe   = 16'sd89;
      dataInIm   = -16'sd10;
      inputValid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (dataOut !== first_exp || outputValid !== 1'b1 || inputReady !== 1'b0) bad++;
         step();
      end
      n_compared++;
      if (bad != 0) begin
         n_failed++;
         $display("[TB] FAIL backpressure_hold %0d bad cycles, dataOut=%0d want %0d", bad, dataOut, first_exp);
      end
      outputReady = 1'b1;
      step();
      n_compared++;
      if (outputValid !== 1'b0 || inputReady !== 1'b1) begin
         n_failed++;
         $display("[TB] FAIL backpressure_release valid=%b ready=%b want 0/1", outputValid, inputReady);
      end
      step();
      inputValid = 1'b0;
      n_compared++;
      if (inputReady !== 1'b0) begin
         n_failed++;
         $display("[TB] FAIL backpressure_second_accept ready=%b want 0", inputReady);
      end
      lat = 0;
      while (!outputValid && lat < WAIT_LIMIT) begin
         step();
         lat++;
      end
      n_compared++;
      if (dataOut !== second_exp || lat !== DW) begin
         n_failed++;
         $display("[TB] FAIL backpressure_second got %0d lat %0d want %0d lat %0d", dataOut, lat, second_exp, DW);
      end
      step();
   endtask

   task automatic test_enable_stall();
      int lat;
      int ready_bad = 0;
      outputReady = 1'b1;
      while (!inputReady) step();
      dataInRe   = 16'sd100;
      dataInIm   = -16'sd200;
      inputValid = 1'b1;
      step();
      inputValid = 1'b0;
      lat = 0;
      repeat (5) begin
         step();
         lat++;
      end
      enable = 1'b0;
      repeat (5) begin
         if (inputReady !== 1'b0 || outputValid !== 1'b0) ready_bad++;
         step();
         lat++;
      end
      enable = 1'b1;
      while (!outputValid && lat < WAIT_LIMIT) begin
         step();
         lat++;
      end
      n_compared++;
      if (ready_bad != 0) begin
         n_failed++;
         $display("[TB] FAIL stall_outputs %0d bad cycles while enable low", ready_bad);
      end
      n_compared++;
      if (lat !== DW + 5 || dataOut !== 32'd50000) begin
         n_failed++;
         $display("[TB] FAIL stall_result got %0d lat %0d want 50000 lat %0d", dataOut, lat, DW + 5);
      end
      step();
   endtask

   task automatic test_async_reset();
      int lat;
      outputReady = 1'b1;
      while (!inputReady) step();
      dataInRe   = 16'sd555;
      dataInIm   = 16'sd777;
      inputValid = 1'b1;
      step();
      inputValid = 1'b0;
      repeat (8) step();
      #2 reset = 1'b1;
      #1;
      n_compared++;
      if (outputValid !== 1'b0 || inputReady !== 1'b1) begin
         n_failed++;
         $display("[TB] FAIL reset_mid_calc valid=%b ready=%b want 0/1", outputValid, inputReady);
      end
      step();
      reset = 1'b0;
      outputReady = 1'b0;
      run_sample(-300, 400, lat);
      #2 reset = 1'b1;
      #1;
      n_compared++;
      if (outputValid !== 1'b0 || inputReady !== 1'b1 || dataOut !== '0) begin
         n_failed++;
         $display("[TB] FAIL reset_in_done valid=%b ready=%b data=%0d want 0/1/0", outputValid, inputReady, dataOut);
      end
      step();
      reset = 1'b0;
      outputReady = 1'b1;
      run_sample(7, -1, lat);
      n_compared++;
      if (dataOut !== 32'd50 || lat !== DW) begin
         n_failed++;
         $display("[TB] FAIL reset_recovery got %0d lat %0d want 50 lat %0d", dataOut, lat, DW);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_corners();
      test_chain_sqrt();
      test_random();
      test_backpressure();
      test_enable_stall();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
      $finish;
   end

endmodule
